mux_nto1_pipe: RTL and testbench

Parametrised N-to-1 word multiplexer with a registered output stage, valid tag, stall/flush control and select-range checking. It generalises the 2:1 operand mux to any channel count and width. Typical uses in the RISC-V datapath are ALU operand selection, forwarding paths and writeback-source selection. It is intended to sit directly on a pipeline-register boundary, so it honours the same stall and flush controls as the surrounding stage.

---
 rtl/mux_nto1_pipe.sv | 87 ++++++++
 tb/tb_mux_nto1_pipe.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/mux_nto1_pipe.sv
// mux_nto1_pipe
//   N-to-1 word multiplexer with a registered output stage. It sits on a
//   pipeline-register boundary and follows the stage's stall/flush controls.
//   Priority on each rising edge: Reset > Flush > Stall > Load.
//
// Parameters
//   WIDTH  data width of each channel and of the output
//   N      channel count, 2..16 (need not be a power of two)
// Ports
//   Clk        rising-edge clock
//   Reset      synchronous active-high reset
//   Num_In     packed channels, channel k at [k*WIDTH +: WIDTH]
//   Selector   binary channel index
//   Valid_In   input word qualifier
//   Stall      hold all registers
//   Flush      insert a bubble (Err_Count untouched)
//   Out_Mux    registered selected word
//   Valid_Out  Out_Mux holds a real transaction
//   Sel_Err    registered transaction had Selector >= N
//   Err_Count  saturating count of accepted out-of-range selects
module mux_nto1_pipe #(
  parameter int WIDTH = 32,
  parameter int N     = 4
) (
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic [N*WIDTH-1:0]         Num_In,
  input  logic [$clog2(N)-1:0]       Selector,
  input  logic                       Valid_In,
  input  logic                       Stall,
  input  logic                       Flush,
  output logic [WIDTH-1:0]           Out_Mux,
  output logic                       Valid_Out,
  output logic                       Sel_Err,
  output logic [7:0]                 Err_Count
);

  localparam int SEL_W = $clog2(N);

  logic [WIDTH-1:0] sel_word;
  logic             in_range;

  // Loop only over existing channels, so an out-of-range index matches
  // nothing and yields zero rather than an X or an out-of-bounds slice.
  always_comb begin
    sel_word = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (Selector == SEL_W'(k)) begin
        sel_word = Num_In[k*WIDTH +: WIDTH];
      end
    end
  end

  assign in_range = (32'(Selector) < 32'(N));

  always_ff @(posedge Clk) begin
    if (Reset) begin
      Out_Mux   <= '0;
      Valid_Out <= 1'b0;
      Sel_Err   <= 1'b0;
      Err_Count <= '0;
    end else if (Flush) begin
      Out_Mux   <= '0;
      Valid_Out <= 1'b0;
      Sel_Err   <= 1'b0;
    end else if (!Stall) begin
      if (Valid_In) begin
        Valid_Out <= 1'b1;
        if (in_range) begin
          Out_Mux <= sel_word;
          Sel_Err <= 1'b0;
        end else begin
          Out_Mux <= '0;
          Sel_Err <= 1'b1;
          if (Err_Count != '1) begin
            Err_Count <= Err_Count + 8'd1;
          end
        end
      end else begin
        Out_Mux   <= '0;
        Valid_Out <= 1'b0;
        Sel_Err   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mux_nto1_pipe.sv
// Directed testbench for mux_nto1_pipe: one N=4 instance (a_*) and one N=3
// instance (b_*) share clock, reset, data, selector, stall and flush; each
// has its own Valid_In so error counting on the N=3 copy is controlled.
module tb_mux_nto1_pipe;

  logic         clk = 1'b0;
  logic         reset;
  logic [127:0] num_in;
  logic [1:0]   selector;
  logic         va, vb;
  logic         stall, flush;

  logic [31:0]  a_out, b_out;
  logic         a_valid, b_valid, a_err, b_err;
  logic [7:0]   a_cnt, b_cnt;

  int unsigned  n_cmp = 0;
  int unsigned  n_bad = 0;

  always #5 clk = ~clk;

  mux_nto1_pipe #(.WIDTH(32), .N(4)) dut_a (
    .Clk(clk), .Reset(reset), .Num_In(num_in), .Selector(selector),
    .Valid_In(va), .Stall(stall), .Flush(flush),
    .Out_Mux(a_out), .Valid_Out(a_valid), .Sel_Err(a_err), .Err_Count(a_cnt)
  );

  mux_nto1_pipe #(.WIDTH(32), .N(3)) dut_b (
    .Clk(clk), .Reset(reset), .Num_In(num_in[95:0]), .Selector(selector),
    .Valid_In(vb), .Stall(stall), .Flush(flush),
    .Out_Mux(b_out), .Valid_Out(b_valid), .Sel_Err(b_err), .Err_Count(b_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_a(input string tag, input logic [31:0] out, input logic valid,
                         input logic err, input logic [7:0] cnt);
    check({tag, ".a_out"},   a_out,          out);
    check({tag, ".a_valid"}, 32'(a_valid),   32'(valid));
    check({tag, ".a_err"},   32'(a_err),     32'(err));
    check({tag, ".a_cnt"},   32'(a_cnt),     32'(cnt));
  endtask

  task automatic check_b(input string tag, input logic [31:0] out, input logic valid,
                         input logic err, input logic [7:0] cnt);
    check({tag, ".b_out"},   b_out,          out);
    check({tag, ".b_valid"}, 32'(b_valid),   32'(valid));
    check({tag, ".b_err"},   32'(b_err),     32'(err));
    check({tag, ".b_cnt"},   32'(b_cnt),     32'(cnt));
  endtask

  logic [31:0] chan [4];

  initial begin
    chan[0] = 32'h1111_1111;
    chan[1] = 32'h2222_2222;
    chan[2] = 32'h3333_3333;
    chan[3] = 32'h4444_4444;

    reset = 1'b1; num_in = '0; selector = '0;
    va = 1'b0; vb = 1'b0; stall = 1'b0; flush = 1'b0;

    // Reset for two cycles
    tick(); tick();
    check_a("reset", 32'h0, 1'b0, 1'b0, 8'd0);
    check_b("reset", 32'h0, 1'b0, 1'b0, 8'd0);

    // Basic selection sweep
    reset  = 1'b0;
    num_in = {chan[3], chan[2], chan[1], chan[0]};
    va     = 1'b1;
    for (int s = 0; s < 4; s++) begin
      selector = 2'(s);
      tick();
      check_a($sformatf("sweep%0d", s), chan[s], 1'b1, 1'b0, 8'd0);
    end

    // Stall hold: register 0x22222222, then stall 3 cycles with sel=3
    selector = 2'd1;
    tick();
    check("pre_stall.a_out", a_out, 32'h2222_2222);
    stall    = 1'b1;
    selector = 2'd3;
    for (int i = 0; i < 3; i++) begin
      va = (i % 2 == 0) ? 1'b0 : 1'b1;
      tick();
      check($sformatf("stall%0d.a_out", i), a_out, 32'h2222_2222);
      check($sformatf("stall%0d.a_valid", i), 32'(a_valid), 32'd1);
    end
    stall = 1'b0;
    va    = 1'b1;
    tick();
    check("post_stall.a_out", a_out, 32'h4444_4444);

    // Out-of-range on N=3 (a stays valid selecting channel 3)
    vb = 1'b1;
    tick();
    check_b("oob1", 32'h0, 1'b1, 1'b1, 8'd1);
    check_a("oob1", 32'h4444_4444, 1'b1, 1'b0, 8'd0);
    vb = 1'b0;
    tick();
    check_b("oob_bubble", 32'h0, 1'b0, 1'b0, 8'd1);
    vb = 1'b1;
    tick();
    check_b("oob2", 32'h0, 1'b1, 1'b1, 8'd2);

    // Flush together with Stall: bubble, counts untouched
    flush = 1'b1; stall = 1'b1;
    tick();
    check_a("flush", 32'h0, 1'b0, 1'b0, 8'd0);
    check_b("flush", 32'h0, 1'b0, 1'b0, 8'd2);
    flush = 1'b0; stall = 1'b0;

    // Saturation: count goes 2 -> 255 after 253 loads, then sticks
    va = 1'b0; vb = 1'b1; selector = 2'd3;
    for (int i = 1; i <= 300; i++) begin
      tick();
      if (i == 252) check("sat252.b_cnt", 32'(b_cnt), 32'd254);
      if (i == 253) check("sat253.b_cnt", 32'(b_cnt), 32'd255);
    end
    check_b("sat300", 32'h0, 1'b1, 1'b1, 8'd255);

    // Reset wins over Stall and Flush
    reset = 1'b1; stall = 1'b1; flush = 1'b1;
    tick();
    check_b("reset2", 32'h0, 1'b0, 1'b0, 8'd0);
    reset = 1'b0; stall = 1'b0; flush = 1'b0; vb = 1'b0;

    // Bubble handling on N=4: alternate valid with sel=1
    selector = 2'd1;
    for (int i = 0; i < 6; i++) begin
      va = (i % 2 == 0);
      tick();
      check($sformatf("bubble%0d.a_valid", i), 32'(a_valid), (i % 2 == 0) ? 32'd1 : 32'd0);
      check($sformatf("bubble%0d.a_out", i), a_out, (i % 2 == 0) ? 32'h2222_2222 : 32'h0);
    end
    check("final.a_cnt", 32'(a_cnt), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
